// File: rtl/alu_8bit.sv
// 8-bit Z80 datapath ALU: arithmetic, logic, shift and rotate.
// Result is registered with one cycle of latency; SET/RES/BIT return zero.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] opcode,
    output logic [7:0] out
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_CPL  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SLA  = 4'd8,
        OP_SRA  = 4'd9,
        OP_ROL  = 4'd10,
        OP_ROR  = 4'd11,
        OP_PASS = 4'd12,
        OP_SET  = 4'd13,
        OP_RES  = 4'd14,
        OP_BIT  = 4'd15
    } op_e;

    logic [7:0] out_q;
    logic [7:0] out_d;

    logic [2:0] amt;
    logic       sh_big;
    logic       fill;

    logic [7:0] shl1, shl2, shl4, shl_res;
    logic [7:0] shr1, shr2, shr4, shr_res;
    logic [7:0] sra1, sra2, sra4, sra_res;
    logic [7:0] rol1, rol2, rol4;
    logic [7:0] ror1, ror2, ror4;

    // Shifts saturate on the full 8-bit amount; rotates use it mod 8.
    assign amt    = b[2:0];
    assign sh_big = |b[7:3];
    assign fill   = a[7];

    always_comb begin
        shl1 = amt[0] ? {a[6:0], 1'b0} : a;
        shl2 = amt[1] ? {shl1[5:0], 2'b00} : shl1;
        shl4 = amt[2] ? {shl2[3:0], 4'h0} : shl2;
        shl_res = sh_big ? 8'h00 : shl4;
    end

    always_comb begin
        shr1 = amt[0] ? {1'b0, a[7:1]} : a;
        shr2 = amt[1] ? {2'b00, shr1[7:2]} : shr1;
        shr4 = amt[2] ? {4'h0, shr2[7:4]} : shr2;
        shr_res = sh_big ? 8'h00 : shr4;
    end

    always_comb begin
        sra1 = amt[0] ? {fill, a[7:1]} : a;
        sra2 = amt[1] ? {{2{fill}}, sra1[7:2]} : sra1;
        sra4 = amt[2] ? {{4{fill}}, sra2[7:4]} : sra2;
        sra_res = sh_big ? {8{fill}} : sra4;
    end

    always_comb begin
        rol1 = amt[0] ? {a[6:0], a[7]} : a;
        rol2 = amt[1] ? {rol1[5:0], rol1[7:6]} : rol1;
        rol4 = amt[2] ? {rol2[3:0], rol2[7:4]} : rol2;
    end

    always_comb begin
        ror1 = amt[0] ? {a[0], a[7:1]} : a;
        ror2 = amt[1] ? {ror1[1:0], ror1[7:2]} : ror1;
        ror4 = amt[2] ? {ror2[3:0], ror2[7:4]} : ror2;
    end

    always_comb begin
        out_d = 8'h00;
        case (opcode)
            OP_ADD:  out_d = a + b;
            OP_SUB:  out_d = a - b;
            OP_AND:  out_d = a & b;
            OP_OR:   out_d = a | b;
            OP_XOR:  out_d = a ^ b;
            OP_CPL:  out_d = ~a;
            OP_SLL:  out_d = shl_res;
            OP_SRL:  out_d = shr_res;
            OP_SLA:  out_d = shl_res;
            OP_SRA:  out_d = sra_res;
            OP_ROL:  out_d = rol4;
            OP_ROR:  out_d = ror4;
            OP_PASS: out_d = a;
            OP_SET,
            OP_RES,
            OP_BIT:  out_d = 8'h00;
            default: out_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 8'h00;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vectors from the
// operation table plus random stimulus against an arithmetic model.
module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] opcode;
    logic [7:0] out;

    int n_tests;
    int n_fail;

    alu_8bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input int op, input int x, input int y);
        int r;
        int sx;
        int k;
        r = 0;
        sx = (x >= 128) ? x - 256 : x;
        k = y % 8;
        case (op)
            0:  r = x + y;
            1:  r = x - y;
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = 255 - x;
            6, 8: r = (y >= 8) ? 0 : (x * (1 << y));
            7:  r = (y >= 8) ? 0 : (x / (1 << y));
            9:  r = (y >= 8) ? ((sx < 0) ? -1 : 0) : (sx >>> y);
            10: r = (x << k) | (x >> (8 - k));
            11: r = (x >> k) | (x << (8 - k));
            12: r = x;
            default: r = 0;
        endcase
        return 8'(r & 255);
    endfunction

    task automatic apply(input logic [3:0] op, input logic [7:0] x,
                         input logic [7:0] y);
        @(negedge clk);
        opcode = op;
        a = x;
        b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [3:0] op,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] exp);
        apply(op, x, y);
        check(tag, out, exp);
    endtask

    initial begin
        logic [3:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        a = 8'd7;
        b = 8'd7;
        opcode = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", out, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("add_after_reset", out, 8'h0E);

        vec("sub_7_7", 4'd1, 8'd7, 8'd7, 8'h00);
        vec("add_wrap", 4'd0, 8'hFF, 8'h01, 8'h00);
        vec("sub_wrap", 4'd1, 8'h00, 8'h01, 8'hFF);
        vec("and", 4'd2, 8'h0D, 8'h07, 8'h05);
        vec("or", 4'd3, 8'hCB, 8'h2B, 8'hEB);
        vec("xor_same", 4'd4, 8'd7, 8'd7, 8'h00);
        vec("xor", 4'd4, 8'hFF, 8'h8A, 8'h75);
        vec("cpl", 4'd5, 8'h0F, 8'h33, 8'hF0);
        vec("sll_3", 4'd6, 8'h07, 8'd3, 8'h38);
        vec("sll_6", 4'd6, 8'h0F, 8'd6, 8'hC0);
        vec("sll_9", 4'd6, 8'h0F, 8'd9, 8'h00);
        vec("srl_3", 4'd7, 8'hCA, 8'd3, 8'h19);
        vec("srl_8", 4'd7, 8'hCA, 8'd8, 8'h00);
        vec("sla_3", 4'd8, 8'h07, 8'd3, 8'h38);
        vec("sla_6", 4'd8, 8'h0F, 8'd6, 8'hC0);
        vec("sla_9", 4'd8, 8'h0F, 8'd9, 8'h00);
        vec("sra_neg3", 4'd9, 8'hCA, 8'd3, 8'hF9);
        vec("sra_pos3", 4'd9, 8'h4A, 8'd3, 8'h09);
        vec("sra_neg8", 4'd9, 8'hCA, 8'd8, 8'hFF);
        vec("sra_pos8", 4'd9, 8'h4A, 8'd8, 8'h00);
        vec("sra_neg200", 4'd9, 8'h80, 8'd200, 8'hFF);
        vec("rol_3", 4'd10, 8'hCA, 8'd3, 8'h56);
        vec("ror_3", 4'd11, 8'hCA, 8'd3, 8'h59);
        vec("rol_8", 4'd10, 8'hCA, 8'd8, 8'hCA);
        vec("ror_11", 4'd11, 8'hCA, 8'd11, 8'h59);
        vec("sll_0", 4'd6, 8'hCA, 8'd0, 8'hCA);
        vec("srl_16", 4'd7, 8'hFF, 8'd16, 8'h00);
        vec("set", 4'd13, 8'd7, 8'd7, 8'h00);
        vec("res", 4'd14, 8'd7, 8'd7, 8'h00);
        vec("bit", 4'd15, 8'd7, 8'd7, 8'h00);
        vec("pass", 4'd12, 8'hA5, 8'h3C, 8'hA5);

        // Inputs changed between edges must not reach out.
        @(negedge clk);
        opcode = 4'd0;
        a = 8'h11;
        b = 8'h22;
        #2;
        check("midcycle_hold", out, 8'hA5);
        @(posedge clk);
        #1;
        check("midcycle_load", out, 8'h33);

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", out, 8'h00);
        @(posedge clk);
        #1;
        check("reset_held_edge", out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_load", out, 8'h33);

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            if (i % 3 == 0)
                rb = 8'($urandom_range(0, 10));
            else
                rb = 8'($urandom);
            apply(rop, ra, rb);
            check($sformatf("rand_op%0d_%02h_%02h", rop, ra, rb),
                  out, model(int'(rop), int'(ra), int'(rb)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit integer ALU for the Z80 datapath: arithmetic, logic, shift and rotate operations on two 8-bit operands, selected by a 4-bit opcode.
- The result is registered: one clock of latency from operands and opcode to `out`.
- Bit-manipulation opcodes (SET/RES/BIT) are reserved and return zero; flag generation belongs to a separate block.

Parameters:
- None. Data width is fixed at 8 and opcode width at 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- a  input  8  operand A; the value that is shifted or rotated.
- b  input  8  operand B; second operand, or the shift/rotate amount (unsigned, full 8 bits).
- opcode  input  4  operation select.
- out  output  8  registered result.

Interface (already decided):
- One clock.
- Reset is asynchronous and active-low.
- Clock and reset ports are named clk and rst_n.

Behaviour:
- Reset:
  - rst_n low forces out = 8'h00 immediately, independent of clk.
  - out holds 8'h00 while rst_n stays low.
  - On deassertion, the first rising edge with rst_n high loads a computed result.
- Timing:
  - A combinational result R(a, b, opcode) is computed continuously.
  - On each rising clk with rst_n high, out <= R.
  - Latency is exactly 1 cycle; a new operation is accepted every cycle.
  - No enable and no handshake.
- Opcode map (results are 8 bits; arithmetic is modulo 256):
  - 0 ADD: a + b, carry-out discarded (8'hFF + 8'h01 = 8'h00).
  - 1 SUB: a - b, two's-complement wrap (8'h00 - 8'h01 = 8'hFF).
  - 2 AND: a & b.
  - 3 OR: a | b.
  - 4 XOR: a ^ b.
  - 5 CPL: ~a; b is ignored.
  - 6 SLL: a << b with zero fill; b >= 8 gives 8'h00.
  - 7 SRL: a >> b with zero fill; b >= 8 gives 8'h00.
  - 8 SLA: identical to SLL, including b >= 8 giving 8'h00.
  - 9 SRA: arithmetic right shift by b, replicating a[7].
    - b >= 8 gives 8'hFF if a[7] = 1, else 8'h00.
  - 10 ROL: rotate a left by b mod 8; b = 0 or 8 returns a unchanged.
  - 11 ROR: rotate a right by b mod 8.
  - 12 PASS: a; b is ignored.
  - 13 SET, 14 RES, 15 BIT: reserved; result is 8'h00 for all operand values.
- Boundary conditions:
  - Shift amounts use the full 8-bit b. Values 8..255 saturate as listed under opcodes 6-9; they do not wrap modulo 8.
  - b = 0 for any shift or rotate returns a.
  - Input changes between edges have no effect on out until the next rising edge.
  - Reset asserted mid-stream discards the pending result; out = 8'h00.
- Undefined values:
  - No X propagation from undefined opcodes, since every opcode is defined.
  - X inputs may produce X on out.

Test Plan:
1. Reset and ADD/SUB:
   - Hold rst_n low with a = 7, b = 7, opcode = 0 and toggle clk -> out = 8'h00.
   - Release rst_n, one edge -> out = 8'h0E.
   - Then opcode 1 with 7, 7 -> 8'h00.
   - 8'hFF + 8'h01 -> 8'h00.
2. Logic ops, checked one edge after each apply:
   - AND 8'h0D, 8'h07 -> 8'h05.
   - OR 8'hCB, 8'h2B -> 8'hEB.
   - XOR 7, 7 -> 8'h00.
   - XOR 8'hFF, 8'h8A -> 8'h75.
   - CPL 8'h0F -> 8'hF0.
3. Logical shifts:
   - SLL 8'h07 by 3 -> 8'h38.
   - SLL 8'h0F by 6 -> 8'hC0.
   - SLL 8'h0F by 9 -> 8'h00.
   - SRL 8'hCA by 3 -> 8'h19.
   - SRL 8'hCA by 8 -> 8'h00.
   - SLA repeats the SLL vectors with identical results.
4. Arithmetic shifts and rotates:
   - SRA 8'hCA by 3 -> 8'hF9.
   - SRA 8'h4A by 3 -> 8'h09.
   - SRA 8'hCA by 8 -> 8'hFF.
   - SRA 8'h4A by 8 -> 8'h00.
   - ROL 8'hCA by 3 -> 8'h56.
   - ROR 8'hCA by 3 -> 8'h59.
5. Reserved and pass-through:
   - Opcodes 13, 14, 15 with 7, 7 -> 8'h00.
   - PASS 8'hA5 -> 8'hA5.
6. Latency and asynchronous reset:
   - Change inputs mid-cycle -> out is unchanged until the next rising edge.
   - Pull rst_n low between edges -> out = 8'h00 immediately, without waiting for an edge.
